// File: rtl/io_port_responder.sv
// io_port_responder: peripheral side of the processor's special-register port
// protocol. Input requests are answered from per-port mailboxes filled by the
// device fabric. Output requests are queued into a FIFO that devices drain.
// Optional feature macro: IORESP_TIMEOUT_EN (bounded WAIT plus sticky err_o).
module io_port_responder #(
    parameter int NUM_PORTS   = 16,
    parameter int PA_WIDTH    = 4,
    parameter int D_WIDTH     = 34,
    parameter int OFIFO_DEPTH = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                clk,
    input  logic                reset_n_i,
    input  logic                in_req_i,
    input  logic [PA_WIDTH-1:0] in_addr_i,
    output logic [D_WIDTH-1:0]  in_data_o,
    output logic                in_ack_o,
    input  logic                out_req_i,
    input  logic [PA_WIDTH-1:0] out_addr_i,
    input  logic [D_WIDTH-1:0]  out_data_i,
    output logic                out_ack_o,
    input  logic                ext_wr_i,
    input  logic [PA_WIDTH-1:0] ext_wr_port_i,
    input  logic [D_WIDTH-1:0]  ext_wr_data_i,
    output logic                ext_wr_ready_o,
    input  logic                ext_rd_i,
    output logic                ext_rd_valid_o,
    output logic [PA_WIDTH-1:0] ext_rd_port_o,
    output logic [D_WIDTH-1:0]  ext_rd_data_o,
    output logic                err_o
);

    localparam int PTR_W = $clog2(OFIFO_DEPTH);
    localparam logic [PA_WIDTH:0] NUM_PORTS_W   = (PA_WIDTH+1)'(NUM_PORTS);
    localparam logic [PTR_W:0]    FIFO_FULL_CNT = (PTR_W+1)'(OFIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_DONE = 2'd3
    } hs_state_t;

    // Mailbox storage: one data word and one full flag per port.
    logic [NUM_PORTS-1:0] mb_full;
    logic [D_WIDTH-1:0]   mb_data [NUM_PORTS];
    logic                 ext_wr_port_ok;
    logic                 mb_consume;

    // Input side.
    hs_state_t           in_state, in_next;
    logic [PA_WIDTH-1:0] in_addr_q;
    logic [D_WIDTH-1:0]  in_data_q;
    logic                in_addr_ok;
    logic                in_load;
    logic [D_WIDTH-1:0]  in_load_val;
    logic                in_timeout;

    // Output side and FIFO.
    hs_state_t           out_state, out_next;
    logic                out_timeout;
    logic [PA_WIDTH-1:0] fifo_port [OFIFO_DEPTH];
    logic [D_WIDTH-1:0]  fifo_data [OFIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [PTR_W:0]      fifo_count;
    logic                fifo_full;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_can_push;

    assign ext_wr_port_ok = ({1'b0, ext_wr_port_i} < NUM_PORTS_W);
    assign ext_wr_ready_o = ext_wr_port_ok && !mb_full[ext_wr_port_i];
    assign in_addr_ok     = ({1'b0, in_addr_q} < NUM_PORTS_W);

    assign in_ack_o  = (in_state == ST_ACK);
    assign out_ack_o = (out_state == ST_ACK);
    assign in_data_o = in_data_q;

    assign fifo_full      = (fifo_count == FIFO_FULL_CNT);
    assign ext_rd_valid_o = (fifo_count != '0);
    assign fifo_pop       = ext_rd_i && ext_rd_valid_o;
    // A pop on the same edge frees the slot the push needs, so a full FIFO
    // being drained still accepts the write.
    assign fifo_can_push  = !fifo_full || fifo_pop;
    assign ext_rd_port_o  = fifo_port[rd_ptr];
    assign ext_rd_data_o  = fifo_data[rd_ptr];

    // Input FSM next state; loads read data and consumes the mailbox on WAIT exit.
    always_comb begin
        in_next     = in_state;
        in_load     = 1'b0;
        in_load_val = '0;
        mb_consume  = 1'b0;
        case (in_state)
            ST_IDLE: begin
                if (in_req_i) in_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (!in_addr_ok) begin
                    in_next     = ST_ACK;
                    in_load     = 1'b1;
                    in_load_val = '1;
                end else if (mb_full[in_addr_q]) begin
                    in_next     = ST_ACK;
                    in_load     = 1'b1;
                    in_load_val = mb_data[in_addr_q];
                    mb_consume  = 1'b1;
                end else if (in_timeout) begin
                    in_next     = ST_ACK;
                    in_load     = 1'b1;
                    in_load_val = '1;
                end
            end
            ST_ACK: begin
                if (!in_req_i) in_next = ST_DONE;
            end
            ST_DONE: in_next = ST_IDLE;
            default: in_next = ST_IDLE;
        endcase
    end

    // Input FSM state register.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) in_state <= ST_IDLE;
        else            in_state <= in_next;
    end

    // Latch the requested port on acceptance and the read data on WAIT exit.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            in_addr_q <= '0;
            in_data_q <= '0;
        end else begin
            if (in_state == ST_IDLE && in_req_i) in_addr_q <= in_addr_i;
            if (in_load) in_data_q <= in_load_val;
        end
    end

    // Mailbox update; a consume needs full=1 and a device write needs full=0,
    // so both can never act on the same mailbox in one cycle.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mb_full <= '0;
            for (int i = 0; i < NUM_PORTS; i++) mb_data[i] <= '0;
        end else begin
            if (mb_consume) mb_full[in_addr_q] <= 1'b0;
            if (ext_wr_i && ext_wr_ready_o) begin
                mb_full[ext_wr_port_i] <= 1'b1;
                mb_data[ext_wr_port_i] <= ext_wr_data_i;
            end
        end
    end

    // Output FSM next state; pushes the held request into the FIFO on WAIT exit.
    always_comb begin
        out_next  = out_state;
        fifo_push = 1'b0;
        case (out_state)
            ST_IDLE: begin
                if (out_req_i) out_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (fifo_can_push) begin
                    out_next  = ST_ACK;
                    fifo_push = 1'b1;
                end else if (out_timeout) begin
                    out_next = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!out_req_i) out_next = ST_DONE;
            end
            ST_DONE: out_next = ST_IDLE;
            default: out_next = ST_IDLE;
        endcase
    end

    // Output FSM state register.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) out_state <= ST_IDLE;
        else            out_state <= out_next;
    end

    // Output FIFO storage and pointers; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < OFIFO_DEPTH; i++) begin
                fifo_port[i] <= '0;
                fifo_data[i] <= '0;
            end
        end else begin
            if (fifo_push) begin
                fifo_port[wr_ptr] <= out_addr_i;
                fifo_data[wr_ptr] <= out_data_i;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (fifo_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef IORESP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] in_wait_cnt, out_wait_cnt;
    logic             err_q;
    logic             in_to_fire, out_to_fire;

    assign in_timeout  = (in_state == ST_WAIT) && (in_wait_cnt == WAIT_LAST);
    assign out_timeout = (out_state == ST_WAIT) && (out_wait_cnt == WAIT_LAST);
    // Only a WAIT exit actually caused by the timer counts as an error.
    assign in_to_fire  = in_timeout && in_addr_ok && !mb_full[in_addr_q];
    assign out_to_fire = out_timeout && !fifo_can_push;
    assign err_o       = err_q;

    // Count cycles spent in WAIT; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            in_wait_cnt  <= '0;
            out_wait_cnt <= '0;
        end else begin
            in_wait_cnt  <= (in_state == ST_WAIT)  ? in_wait_cnt + CNT_W'(1)  : '0;
            out_wait_cnt <= (out_state == ST_WAIT) ? out_wait_cnt + CNT_W'(1) : '0;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) err_q <= 1'b0;
        else if (in_to_fire || out_to_fire) err_q <= 1'b1;
    end
`else
    assign in_timeout  = 1'b0;
    assign out_timeout = 1'b0;
    assign err_o       = 1'b0;
`endif

endmodule
